sd_spi_cmd_engine: RTL

Parametrised SD-card SPI-mode command engine, the successor to the single-CMD0 bring-up test block. It optionally emits the 80-clock power-up preamble, then frames and sends any 48-bit command (index, argument, CRC7). It waits for the card's response within a bounded timeout and captures an R1 (8-bit) or R3/R7 (40-bit) response. It sits between the card-init/sector-read controller and the SD pins, with a start/done handshake.

---
 rtl/sd_spi_cmd_engine.sv | 338 +++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/sd_spi_cmd_engine.sv
// -----------------------------------------------------------------------------
// sd_spi_cmd_engine
//
// SD-card SPI-mode command engine. For each request it optionally sends the
// power-up preamble (CS high, MOSI high), frames and shifts out one 48-bit
// command {01, index, argument, crc7, 1} MSB first, waits a bounded number of
// clocks for the card's response start bit, captures an R1 (8-bit) or R3/R7
// (40-bit) response and finishes with trailing clocks with CS high.
//
// Build option:
//   SD_CRC7_EN  defined   -> crc7 computed over the first 40 frame bits
//               undefined -> crc7 from a small table (CMD0, CMD8, else 7'h7F)
//
// Ports:
//   CLOCK_27   in   system clock (27 MHz)
//   RST        in   asynchronous, active-high reset
//   start      in   one-cycle request, accepted only while busy = 0
//   init       in   with start: prepend INIT_CLKS preamble clocks
//   cmd_index  in   with start: 6-bit command index
//   cmd_arg    in   with start: 32-bit command argument
//   resp_long  in   with start: 0 = R1 (8 bits), 1 = R3/R7 (40 bits)
//   busy       out  high from the cycle after acceptance until done
//   done       out  one-cycle pulse at the end of the transaction
//   timeout    out  valid with done: no response start bit seen
//   resp       out  response, right-justified (R1 in resp[7:0])
//   sdclk      out  SPI clock, mode 0, idle low
//   mosi       out  data to card
//   miso       in   data from card
//   cs_n       out  chip select, active low
// -----------------------------------------------------------------------------
module sd_spi_cmd_engine #(
    parameter int DIV_POW2     = 6,
    parameter int INIT_CLKS    = 80,
    parameter int NCR_MAX_CLKS = 64,
    parameter int POST_CLKS    = 8
) (
    input  logic        CLOCK_27,
    input  logic        RST,
    input  logic        start,
    input  logic        init,
    input  logic [5:0]  cmd_index,
    input  logic [31:0] cmd_arg,
    input  logic        resp_long,
    output logic        busy,
    output logic        done,
    output logic        timeout,
    output logic [39:0] resp,
    output logic        sdclk,
    output logic        mosi,
    input  logic        miso,
    output logic        cs_n
);

    localparam int FRAME_BITS = 48;
    localparam int CNT_MAX_A  = (INIT_CLKS > NCR_MAX_CLKS) ? INIT_CLKS : NCR_MAX_CLKS;
    localparam int CNT_MAX_B  = (POST_CLKS > FRAME_BITS) ? POST_CLKS : FRAME_BITS;
    localparam int CNT_MAX    = (CNT_MAX_A > CNT_MAX_B) ? CNT_MAX_A : CNT_MAX_B;
    localparam int CNT_W      = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(32'd1);
    localparam logic [CNT_W-1:0] CNT_SAT   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(INIT_CLKS - 32'd1);
    localparam logic [CNT_W-1:0] NCR_LAST  = CNT_W'(NCR_MAX_CLKS - 32'd1);
    localparam logic [CNT_W-1:0] POST_END  = CNT_W'(POST_CLKS);
    localparam logic [CNT_W-1:0] FRAME_END = CNT_W'(FRAME_BITS);
    // Response bit counts include the start bit taken in WAIT.
    localparam logic [CNT_W-1:0] R1_LAST   = CNT_W'(32'd7);
    localparam logic [CNT_W-1:0] R3_LAST   = CNT_W'(32'd39);

    // Rise at half-count, fall at wrap: 50 % duty, low phase first.
    localparam logic [DIV_POW2-1:0] DIV_RISE = {1'b0, {(DIV_POW2-1){1'b1}}};
    localparam logic [DIV_POW2-1:0] DIV_FALL = {DIV_POW2{1'b1}};
    localparam logic [DIV_POW2-1:0] DIV_ONE  = DIV_POW2'(32'd1);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_INIT = 3'd1,
        ST_SEND = 3'd2,
        ST_WAIT = 3'd3,
        ST_RECV = 3'd4,
        ST_POST = 3'd5
    } state_t;

`ifdef SD_CRC7_EN
    // Bit-serial CRC7 (x^7 + x^3 + 1) over the 40 leading frame bits, MSB first.
    function automatic logic [6:0] crc7_serial(input logic [39:0] bits);
        logic [6:0] crc;
        logic       fb;
        crc = 7'h00;
        for (int i = 39; i >= 0; i--) begin
            fb  = bits[i] ^ crc[6];
            crc = {crc[5:0], 1'b0};
            if (fb) begin
                crc = crc ^ 7'h09;
            end else begin
                crc = crc;
            end
        end
        return crc;
    endfunction
`else
    // Only CMD0 and CMD8 need a valid CRC in SPI mode; everything else gets 7'h7F.
    function automatic logic [6:0] crc7_lookup(input logic [5:0] idx);
        logic [6:0] crc;
        case (idx)
            6'd0:    crc = 7'h4A;
            6'd8:    crc = 7'h43;
            default: crc = 7'h7F;
        endcase
        return crc;
    endfunction
`endif

    state_t                state_r, state_s;
    logic [DIV_POW2-1:0]   div_cnt_r, div_cnt_s;
    logic [CNT_W-1:0]      cnt_r, cnt_s, cnt_inc_s;
    logic [FRAME_BITS-1:0] shift_r, shift_s;
    logic                  long_r, long_s;
    logic                  busy_r, busy_s;
    logic                  done_r, done_s;
    logic                  timeout_r, timeout_s;
    logic [39:0]           resp_r, resp_s;
    logic                  sdclk_r, sdclk_s;
    logic                  mosi_r, mosi_s;
    logic                  cs_n_r, cs_n_s;
    logic                  rise_s, fall_s;
    logic [6:0]            crc_s;
    logic [CNT_W-1:0]      rx_last_s;

    // Strobes, saturating counter increment and frame CRC.
    always_comb begin
        rise_s    = (state_r != ST_IDLE) && (div_cnt_r == DIV_RISE);
        fall_s    = (state_r != ST_IDLE) && (div_cnt_r == DIV_FALL);
        cnt_inc_s = (cnt_r == CNT_SAT) ? cnt_r : (cnt_r + CNT_ONE);
        rx_last_s = long_r ? R3_LAST : R1_LAST;
`ifdef SD_CRC7_EN
        crc_s     = crc7_serial({2'b01, cmd_index, cmd_arg});
`else
        crc_s     = crc7_lookup(cmd_index);
`endif
    end

    // Next-state and next-output logic.
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        shift_s   = shift_r;
        long_s    = long_r;
        busy_s    = busy_r;
        done_s    = 1'b0;
        timeout_s = timeout_r;
        resp_s    = resp_r;
        mosi_s    = mosi_r;
        cs_n_s    = cs_n_r;
        div_cnt_s = (state_r == ST_IDLE) ? {DIV_POW2{1'b0}} : (div_cnt_r + DIV_ONE);

        if (state_r == ST_IDLE) begin
            sdclk_s = 1'b0;
        end else if (rise_s) begin
            sdclk_s = 1'b1;
        end else if (fall_s) begin
            sdclk_s = 1'b0;
        end else begin
            sdclk_s = sdclk_r;
        end

        case (state_r)
            ST_IDLE: begin
                mosi_s = 1'b1;
                cs_n_s = 1'b1;
                if (start) begin
                    state_s   = init ? ST_INIT : ST_SEND;
                    cnt_s     = CNT_ZERO;
                    shift_s   = {2'b01, cmd_index, cmd_arg, crc_s, 1'b1};
                    long_s    = resp_long;
                    busy_s    = 1'b1;
                    timeout_s = 1'b0;
                    resp_s    = 40'h00_0000_0000;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_INIT: begin
                if (rise_s) begin
                    if (cnt_r == INIT_LAST) begin
                        state_s = ST_SEND;
                        cnt_s   = CNT_ZERO;
                    end else begin
                        cnt_s = cnt_inc_s;
                    end
                end else if (fall_s) begin
                    mosi_s = 1'b1;
                    cs_n_s = 1'b1;
                end else begin
                    cnt_s = cnt_r;
                end
            end
            ST_SEND: begin
                // CS drops together with the first frame bit, so every clock
                // before it (preamble or lead-in) is seen with CS high.
                if (fall_s) begin
                    if (cnt_r != FRAME_END) begin
                        mosi_s  = shift_r[FRAME_BITS-1];
                        shift_s = {shift_r[FRAME_BITS-2:0], 1'b1};
                        cnt_s   = cnt_inc_s;
                        cs_n_s  = 1'b0;
                    end else begin
                        cnt_s = cnt_r;
                    end
                end else if (rise_s) begin
                    // Leave once the card has clocked in the last frame bit.
                    if (cnt_r == FRAME_END) begin
                        state_s = ST_WAIT;
                        cnt_s   = CNT_ZERO;
                    end else begin
                        cnt_s = cnt_r;
                    end
                end else begin
                    cnt_s = cnt_r;
                end
            end
            ST_WAIT: begin
                if (rise_s) begin
                    if (miso == 1'b0) begin
                        // Start bit is the response MSB; checked before the
                        // limit so a start bit on the last sample still counts.
                        state_s = ST_RECV;
                        resp_s  = {resp_r[38:0], miso};
                        cnt_s   = CNT_ONE;
                    end else if (cnt_r == NCR_LAST) begin
                        state_s   = ST_POST;
                        timeout_s = 1'b1;
                        resp_s    = 40'h00_0000_0000;
                        cnt_s     = CNT_ZERO;
                    end else begin
                        cnt_s = cnt_inc_s;
                    end
                end else if (fall_s) begin
                    mosi_s = 1'b1;
                    cs_n_s = 1'b0;
                end else begin
                    cnt_s = cnt_r;
                end
            end
            ST_RECV: begin
                if (rise_s) begin
                    resp_s = {resp_r[38:0], miso};
                    if (cnt_r == rx_last_s) begin
                        state_s = ST_POST;
                        cnt_s   = CNT_ZERO;
                    end else begin
                        cnt_s = cnt_inc_s;
                    end
                end else if (fall_s) begin
                    mosi_s = 1'b1;
                    cs_n_s = 1'b0;
                end else begin
                    cnt_s = cnt_r;
                end
            end
            ST_POST: begin
                if (rise_s) begin
                    cnt_s = cnt_inc_s;
                end else if (fall_s) begin
                    mosi_s = 1'b1;
                    cs_n_s = 1'b1;
                    // Finish on the fall after the last trailing clock so
                    // sdclk is already low when returning to IDLE.
                    if (cnt_r == POST_END) begin
                        state_s = ST_IDLE;
                        cnt_s   = CNT_ZERO;
                        done_s  = 1'b1;
                        busy_s  = 1'b0;
                    end else begin
                        cnt_s = cnt_r;
                    end
                end else begin
                    cnt_s = cnt_r;
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = CNT_ZERO;
                busy_s  = 1'b0;
                mosi_s  = 1'b1;
                cs_n_s  = 1'b1;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge CLOCK_27 or posedge RST) begin
        if (RST) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge CLOCK_27 or posedge RST) begin
        if (RST) begin
            div_cnt_r <= {DIV_POW2{1'b0}};
            cnt_r     <= CNT_ZERO;
            shift_r   <= {FRAME_BITS{1'b1}};
            long_r    <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            timeout_r <= 1'b0;
            resp_r    <= 40'h00_0000_0000;
            sdclk_r   <= 1'b0;
            mosi_r    <= 1'b1;
            cs_n_r    <= 1'b1;
        end else begin
            div_cnt_r <= div_cnt_s;
            cnt_r     <= cnt_s;
            shift_r   <= shift_s;
            long_r    <= long_s;
            busy_r    <= busy_s;
            done_r    <= done_s;
            timeout_r <= timeout_s;
            resp_r    <= resp_s;
            sdclk_r   <= sdclk_s;
            mosi_r    <= mosi_s;
            cs_n_r    <= cs_n_s;
        end
    end

    assign busy    = busy_r;
    assign done    = done_r;
    assign timeout = timeout_r;
    assign resp    = resp_r;
    assign sdclk   = sdclk_r;
    assign mosi    = mosi_r;
    assign cs_n    = cs_n_r;

endmodule
